// File: rtl/wb_interconnect_if.sv
// Wishbone bus bundle: one master port plus the broadcast/one-hot slave side of the interconnect.
// The master modport is the bus owner (CPU side, which also models the peripherals in a bench).
interface wb_interconnect_if #(
    parameter int NUM_SLAVES = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic                             m_cyc;
    logic                             m_stb;
    logic                             m_we;
    logic [SEL_WIDTH-1:0]             m_sel;
    logic [ADDR_WIDTH-1:0]            m_adr;
    logic [DATA_WIDTH-1:0]            m_dat_w;
    logic [DATA_WIDTH-1:0]            m_dat_r;
    logic                             m_ack;
    logic                             m_err;

    logic                             s_cyc;
    logic                             s_we;
    logic [SEL_WIDTH-1:0]             s_sel;
    logic [ADDR_WIDTH-1:0]            s_adr;
    logic [DATA_WIDTH-1:0]            s_dat_w;
    logic [NUM_SLAVES-1:0]            s_stb;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_r;
    logic [NUM_SLAVES-1:0]            s_ack;

    modport master (
        output m_cyc, m_stb, m_we, m_sel, m_adr, m_dat_w, s_dat_r, s_ack,
        input  m_dat_r, m_ack, m_err, s_cyc, s_we, s_sel, s_adr, s_dat_w, s_stb
    );

    modport slave (
        input  m_cyc, m_stb, m_we, m_sel, m_adr, m_dat_w, s_dat_r, s_ack,
        output m_dat_r, m_ack, m_err, s_cyc, s_we, s_sel, s_adr, s_dat_w, s_stb
    );
endinterface

// File: rtl/wb_interconnect.sv
// Single-master Wishbone interconnect: registered decode, decode-miss error, ack watchdog, sticky error capture.
// Two cycles minimum per transfer (ack/data combinational in BUSY); master waits for m_ack/m_err, stuck slaves cut off by timeout.
module wb_interconnect #(
    parameter int                                NUM_SLAVES     = 6,
    parameter int                                ADDR_WIDTH     = 32,
    parameter int                                DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLAVE_BASE     = {NUM_SLAVES{ADDR_WIDTH'(32'h0)}},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLAVE_SIZE     = {NUM_SLAVES{ADDR_WIDTH'(32'h40)}},
    parameter int                                TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0]             ERR_DATA       = DATA_WIDTH'(32'hDEADBEEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wb_interconnect_if.slave      bus,
    input  logic                  err_clear,
    output logic                  err_valid,
    output logic                  err_cause,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [7:0]            err_count
);
    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                state;
    logic [NUM_SLAVES-1:0] sel_q;
    logic [NUM_SLAVES-1:0] hit_sel;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [15:0]           tmo_cnt;
    logic [ADDR_WIDTH:0]   adr_ext;
    logic [ADDR_WIDTH:0]   base_ext;
    logic [ADDR_WIDTH:0]   lim_ext;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic                  busy;
    logic                  slv_ack;
    logic                  tmo_last;
    logic                  tmo_hit;

    assign adr_ext = {1'b0, bus.m_adr};

    // Walk from the top index down so the lowest matching window overrides.
    always_comb begin
        hit_sel  = '0;
        base_ext = '0;
        lim_ext  = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            base_ext = {1'b0, SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]};
            lim_ext  = base_ext + {1'b0, SLAVE_SIZE[i*ADDR_WIDTH +: ADDR_WIDTH]};
            if (SLAVE_SIZE[i*ADDR_WIDTH +: ADDR_WIDTH] != '0 &&
                adr_ext >= base_ext && adr_ext < lim_ext) begin
                hit_sel = NUM_SLAVES'(1) << i;
            end
        end
    end

    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                sel_dat = sel_dat | bus.s_dat_r[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign busy     = (state == BUSY);
    assign slv_ack  = busy && |(bus.s_ack & sel_q);
    assign tmo_last = busy && (tmo_cnt == TMO_LAST);
    assign tmo_hit  = tmo_last && !slv_ack;

    assign bus.m_ack   = slv_ack;
    assign bus.m_err   = (state == ERR) || tmo_hit;
    assign bus.m_dat_r = slv_ack ? sel_dat : (bus.m_err ? ERR_DATA : '0);

    // Strobe drop on the last watchdog cycle depends only on state, so no path from s_ack back to s_stb.
    assign bus.s_stb   = (busy && !tmo_last) ? (sel_q & {NUM_SLAVES{bus.m_stb}}) : '0;
    assign bus.s_cyc   = bus.m_cyc;
    assign bus.s_we    = bus.m_we;
    assign bus.s_sel   = bus.m_sel;
    assign bus.s_adr   = bus.m_adr;
    assign bus.s_dat_w = bus.m_dat_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_q   <= '0;
            adr_q   <= '0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.m_cyc && bus.m_stb) begin
                        sel_q   <= hit_sel;
                        adr_q   <= bus.m_adr;
                        tmo_cnt <= '0;
                        state   <= (|hit_sel) ? BUSY : ERR;
                    end
                end
                BUSY: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (slv_ack || tmo_last || !bus.m_cyc) begin
                        state <= IDLE;
                    end
                end
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // First uncleared error keeps its cause/address; a clear in the same cycle as a new error yields to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid <= 1'b0;
            err_cause <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else if (bus.m_err) begin
            err_valid <= 1'b1;
            if (!err_valid || err_clear) begin
                err_cause <= tmo_hit;
                err_addr  <= adr_q;
            end
            if (err_clear) begin
                err_count <= 8'd1;
            end else if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end else if (err_clear) begin
            err_valid <= 1'b0;
            err_count <= '0;
        end
    end
endmodule

// File: tb/tb_wb_interconnect.sv
// Randomised and directed bench for wb_interconnect against a transaction-level model of the bus map and error status.
module tb_wb_interconnect;
    localparam int NS = 6;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_interconnect_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    logic          err_clear;
    logic          err_valid;
    logic          err_cause;
    logic [AW-1:0] err_addr;
    logic [7:0]    err_count;

    wb_interconnect #(
        .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .SLAVE_BASE({32'h0030_0000, 32'hFFFF_FF00, 32'h0010_0000, 32'h0000_0100, 32'h0000_0040, 32'h0000_0000}),
        .SLAVE_SIZE({32'h0000_0000, 32'h0000_0100, 32'h0000_1000, 32'h0010_0000, 32'h0000_0040, 32'h0000_0040}),
        .TIMEOUT_CYCLES(TO), .ERR_DATA(ERRD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .err_clear(err_clear),
        .err_valid(err_valid), .err_cause(err_cause), .err_addr(err_addr), .err_count(err_count)
    );

    // Memory map as the model sees it: GPIO, UART, RAM, overlapping window, top-of-space window, disabled.
    longint unsigned mb [NS] = '{64'h0, 64'h40, 64'h100, 64'h100000, 64'hFFFFFF00, 64'h300000};
    longint unsigned ms [NS] = '{64'h40, 64'h40, 64'h100000, 64'h1000, 64'h100, 64'h0};
    logic [31:0] edges [13] = '{32'h3F, 32'h40, 32'h7F, 32'h80, 32'hFF, 32'h100, 32'h1000FF,
                                32'h100100, 32'h100FFF, 32'h101000, 32'hFFFFFEFF, 32'hFFFFFF00, 32'hFFFFFFFF};

    int checks = 0;
    int errors = 0;

    logic [NS*DW-1:0] sdat;
    logic [NS-1:0]    sack;
    assign bus.s_dat_r = sdat;
    assign bus.s_ack   = sack;

    logic [NS-1:0] exp_stb;
    logic          exp_ack, exp_err, exp_cause;
    logic [31:0]   exp_dat, exp_eaddr;
    logic          clr_en, spur_all, clr_on_err;

    logic          mv, mc;
    logic [31:0]   ma;
    logic [7:0]    mn;

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if (ms[i] != 0 && a >= mb[i] && a < mb[i] + ms[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_stb = '0; exp_ack = 1'b0; exp_err = 1'b0; exp_dat = '0; exp_cause = 1'b0; exp_eaddr = '0;
    endtask

    task automatic rnd_slaves(input int tgt);
        logic [NS-1:0] a;
        for (int i = 0; i < NS; i++) sdat[i*DW +: DW] = $urandom;
        a = spur_all ? '1 : (NS'($urandom) & NS'($urandom));
        if (tgt >= 0) a[tgt] = 1'b0;
        sack = a;
        err_clear = clr_en && ($urandom_range(0, 7) == 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            bus.m_cyc = 1'($urandom_range(0, 1)); bus.m_stb = 1'b0;
            bus.m_adr = $urandom; bus.m_dat_w = $urandom;
            set_idle_exp(); rnd_slaves(-1);
            tick();
        end
    endtask

    // One transfer: request presented in the current (idle) cycle; slave acks lat cycles later (0 = never);
    // abort_at drops cyc/stb in that BUSY cycle.
    task automatic xfer(input logic [31:0] adr, input int lat, input int abort_at, input logic [31:0] rdat);
        int tgt;
        logic [NS-1:0] oh;
        tgt = ref_decode(adr);
        bus.m_cyc = 1'b1; bus.m_stb = 1'b1; bus.m_we = 1'($urandom_range(0, 1));
        bus.m_sel = 4'($urandom); bus.m_adr = adr; bus.m_dat_w = $urandom;
        set_idle_exp(); rnd_slaves(-1);
        tick();
        if (tgt < 0) begin
            set_idle_exp(); rnd_slaves(-1);
            if (clr_on_err) err_clear = 1'b1;
            exp_err = 1'b1; exp_dat = ERRD; exp_cause = 1'b0; exp_eaddr = adr;
            tick();
        end else begin
            oh = NS'(1) << tgt;
            for (int j = 1; j <= TO; j++) begin
                set_idle_exp(); rnd_slaves(tgt);
                if (j == abort_at) begin
                    bus.m_cyc = 1'b0; bus.m_stb = 1'b0;
                    tick();
                    break;
                end
                exp_stb = (j == TO) ? '0 : oh;
                if (j == lat) begin
                    sack[tgt] = 1'b1; sdat[tgt*DW +: DW] = rdat;
                    exp_ack = 1'b1; exp_dat = rdat;
                    tick();
                    break;
                end
                if (j == TO) begin
                    exp_err = 1'b1; exp_dat = ERRD; exp_cause = 1'b1; exp_eaddr = adr;
                    tick();
                    bus.m_cyc = 1'b0; bus.m_stb = 1'b0;
                    set_idle_exp(); rnd_slaves(-1); sack[tgt] = 1'b1;
                    tick();
                    break;
                end
                tick();
            end
        end
    endtask

    // Compare process: outputs every cycle, then fold this cycle's error event into the status model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mv = 1'b0; mc = 1'b0; ma = '0; mn = '0;
                chk("rst_s_stb", 128'(bus.s_stb), 128'(0));
                chk("rst_m_ack_err", 128'({bus.m_ack, bus.m_err}), 128'(0));
                chk("rst_m_dat_r", 128'(bus.m_dat_r), 128'(0));
                chk("rst_err_status", 128'({err_valid, err_cause, err_addr, err_count}), 128'(0));
            end else begin
                chk("s_stb", 128'(bus.s_stb), 128'(exp_stb));
                chk("m_ack", 128'(bus.m_ack), 128'(exp_ack));
                chk("m_err", 128'(bus.m_err), 128'(exp_err));
                chk("m_dat_r", 128'(bus.m_dat_r), 128'(exp_dat));
                chk("broadcast", 128'({bus.s_cyc, bus.s_we, bus.s_sel, bus.s_adr, bus.s_dat_w}),
                    128'({bus.m_cyc, bus.m_we, bus.m_sel, bus.m_adr, bus.m_dat_w}));
                chk("err_valid", 128'(err_valid), 128'(mv));
                chk("err_cause", 128'(err_cause), 128'(mc));
                chk("err_addr", 128'(err_addr), 128'(ma));
                chk("err_count", 128'(err_count), 128'(mn));
                if (exp_err) begin
                    if (!mv || err_clear) begin mc = exp_cause; ma = exp_eaddr; end
                    mv = 1'b1;
                    mn = err_clear ? 8'd1 : ((mn == 8'hFF) ? mn : mn + 8'd1);
                end else if (err_clear) begin
                    mv = 1'b0; mn = '0;
                end
            end
        end
    end

    initial begin
        int r, i, lat, ab;
        logic [31:0] adr;
        bus.m_cyc = 1'b0; bus.m_stb = 1'b0; bus.m_we = 1'b0; bus.m_sel = '0; bus.m_adr = '0; bus.m_dat_w = '0;
        err_clear = 1'b0; clr_en = 1'b0; spur_all = 1'b0; clr_on_err = 1'b0;
        sdat = '0; sack = '0;
        set_idle_exp();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("pin_dec_uart", 128'(ref_decode(32'h44)), 128'(1));
        chk("pin_dec_overlap", 128'(ref_decode(32'h100010)), 128'(2));
        chk("pin_dec_slave3", 128'(ref_decode(32'h100100)), 128'(3));
        chk("pin_dec_top", 128'(ref_decode(32'hFFFFFFFF)), 128'(4));
        chk("pin_dec_disabled", 128'(ref_decode(32'h300000)), 128'(-1));
        chk("pin_dec_gap", 128'(ref_decode(32'h80)), 128'(-1));

        idle(1);
        xfer(32'h44, 2, 0, 32'h1234);
        idle(1);
        xfer(32'h0020_0000, 0, 0, 32'h0);
        chk("pin_miss_status", 128'({err_valid, err_cause, err_addr, err_count}), 128'({1'b1, 1'b0, 32'h0020_0000, 8'd1}));
        idle(1);
        xfer(32'h10, 0, 0, 32'h0);
        chk("pin_tmo_first_held", 128'({err_valid, err_cause, err_addr, err_count}), 128'({1'b1, 1'b0, 32'h0020_0000, 8'd2}));

        spur_all = 1'b1;
        xfer(32'h100010, 3, 0, 32'hA5A5_0003);
        spur_all = 1'b0;

        clr_on_err = 1'b1;
        xfer(32'h0030_0000, 0, 0, 32'h0);
        clr_on_err = 1'b0;
        chk("pin_clear_vs_new", 128'({err_valid, err_cause, err_addr, err_count}), 128'({1'b1, 1'b0, 32'h0030_0000, 8'd1}));

        bus.m_cyc = 1'b0; bus.m_stb = 1'b0; set_idle_exp(); rnd_slaves(-1); err_clear = 1'b1;
        tick();
        chk("pin_clear", 128'({err_valid, err_count}), 128'(0));

        xfer(32'h44, 0, 2, 32'h0);
        idle(1);

        xfer(32'hFFFF_FFF0, 1, 0, 32'hCAFE_F00D);
        xfer(32'h10, 3, 0, 32'h0000_0010);

        // Mid-BUSY asynchronous reset.
        bus.m_cyc = 1'b1; bus.m_stb = 1'b1; bus.m_adr = 32'h20; set_idle_exp(); rnd_slaves(-1);
        tick();
        set_idle_exp(); rnd_slaves(0); exp_stb = NS'(1);
        tick();
        set_idle_exp(); rnd_slaves(0); exp_stb = NS'(1);
        tick();
        rst_n = 1'b0; bus.m_cyc = 1'b0; bus.m_stb = 1'b0; set_idle_exp(); rnd_slaves(-1);
        tick();
        rst_n = 1'b1;
        chk("pin_after_reset", 128'({err_valid, err_cause, err_addr, err_count, bus.s_stb}), 128'(0));
        idle(1);
        xfer(32'h40, 1, 0, 32'h5555_AAAA);

        for (int k = 0; k < 260; k++) xfer(32'h80 + 32'(k), 0, 0, 32'h0);
        chk("pin_saturate", 128'(err_count), 128'(8'hFF));

        clr_en = 1'b1;
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 3);
            if (r <= 1) begin
                i = $urandom_range(0, NS - 1);
                adr = 32'(mb[i]) + ((ms[i] == 0) ? 32'h0 : 32'($urandom % 32'(ms[i])));
            end else if (r == 2) begin
                adr = $urandom;
            end else begin
                adr = edges[$urandom_range(0, 12)];
            end
            lat = $urandom_range(1, TO + 2);
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, TO - 1) : 0;
            xfer(adr, lat, ab, $urandom);
            idle($urandom_range(0, 2));
        end
        clr_en = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_interconnect.md
# wb_interconnect

Parametrised single-master Wishbone (classic) interconnect that replaces the fixed, combinational address-decode and ack/data OR-mux of the SoC top level. It sits between the CPU's data bus and NUM_SLAVES peripherals (GPIO, UART, timer, RAM, instruction memory, external bus). Per-slave address windows are set by parameters. The block registers the decode and adds a bus-error response for unmapped addresses. It also adds a watchdog timeout for slaves that never acknowledge, plus sticky error-capture status.

## Interface
- NUM_SLAVES, 6, number of slave ports (1..16)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; SEL_WIDTH = DATA_WIDTH/8
- SLAVE_BASE, {NUM_SLAVES{32'h0}}, packed NUM_SLAVES*ADDR_WIDTH base addresses; slave i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- SLAVE_SIZE, {NUM_SLAVES{32'h40}}, packed window sizes in bytes; 0 disables slave
- TIMEOUT_CYCLES, 255, cycles in BUSY without ack before timeout (1..65535)
- ERR_DATA, 32'hDEADBEEF, value on m_dat_r during m_err
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- m_cyc, m_stb, m_we  in  1 each  master cycle/strobe/write
- m_sel  in  SEL_WIDTH  byte select
- m_adr  in  ADDR_WIDTH  address
- m_dat_w  in  DATA_WIDTH  write data
- m_dat_r  out  DATA_WIDTH  read data
- m_ack  out  1  transfer acknowledge
- m_err  out  1  bus error, one-cycle pulse
- s_cyc, s_we  out  1  broadcast of m_cyc, m_we
- s_sel, s_adr, s_dat_w  out  as master  broadcast of master signals
- s_stb  out  NUM_SLAVES  one-hot per-slave strobe
- s_dat_r  in  NUM_SLAVES*DATA_WIDTH  packed slave read data
- s_ack  in  NUM_SLAVES  slave acknowledges
- err_clear  in  1  clears the sticky error status
- err_valid  out  1  sticky error flag
- err_cause  out  1  0 = decode miss, 1 = timeout
- err_addr  out  ADDR_WIDTH  address of the first uncleared error
- err_count  out  8  saturating error counter, cleared by err_clear

## Operation
- FSM states: IDLE, BUSY, ERR.
- IDLE: if m_cyc&&m_stb, decode m_adr.
  - hit_i = SIZE_i!=0 && adr>=BASE_i && adr<BASE_i+SIZE_i, compared in ADDR_WIDTH+1 bits so windows ending at the top of the space do not wrap.
  - Overlapping windows: the lowest index wins.
  - Latch the one-hot sel_q and adr_q. On a hit go to BUSY, otherwise go to ERR.
- BUSY: s_stb = sel_q & {NUM_SLAVES{m_stb}}. The timeout counter increments each cycle.
  - If s_ack[sel]: m_ack=1 and m_dat_r=s_dat_r[sel], both combinational in the same cycle; go to IDLE.
  - Else if counter==TIMEOUT_CYCLES-1: m_err=1 and s_stb drops; go to IDLE.
  - Else if !m_cyc (master abort): go to IDLE with no ack and no err.
- ERR: m_err=1 for exactly one cycle with m_dat_r=ERR_DATA; go to IDLE.
- Acks from non-selected slaves, and any ack while in IDLE or ERR, are ignored.
- m_dat_r is 0 whenever neither m_ack nor m_err is asserted.
- Error capture: on a decode miss or timeout, err_valid=1.
  - err_cause and err_addr are loaded only if err_valid was 0 (first error held).
  - err_count increments and saturates at 255.
- err_clear zeroes err_valid and err_count. If it coincides with a new error, the new error wins: err_valid=1, count=1, fields loaded.

## Timing
- Reset values: state IDLE; s_stb=0; m_ack=0; m_err=0; m_dat_r=0; err_valid=0; err_cause=0; err_addr=0; err_count=0; counter=0.
- Request sampled at edge T; s_stb is high from T+1.
- With a slave acking at T+k (k≥1), m_ack is high at T+k and the FSM is in IDLE at T+k+1.
- Minimum of 2 cycles per transfer. A back-to-back request is sampled in the IDLE cycle.
- A decode miss gives m_err at T+1.
- A timeout gives m_err in the TIMEOUT_CYCLES-th BUSY cycle. The counter clears on entry to BUSY.
- Asynchronous reset mid-transfer forces IDLE and deasserts all strobes immediately.

## Test plan
- Default-style map (GPIO 0x0/0x40, UART 0x40/0x40, RAM 0x100/0x100000); read 0x44, UART acks at T+2 with 0x1234 -> s_stb[1] high T+1..T+2, m_ack at T+2, m_dat_r=0x1234, other s_stb stay 0.
- Read 0x00200000 (unmapped) -> m_err at T+1, m_dat_r=0xDEADBEEF, err_valid=1, cause=0, err_addr=0x00200000, count=1.
- TIMEOUT_CYCLES=4, slave never acks -> m_err in the 4th BUSY cycle, cause=1; a late s_ack afterwards produces no m_ack.
- Overlapping windows on slaves 2 and 3 -> only s_stb[2] asserted; spurious s_ack[3] ignored.
- Second error after the first, then err_clear coinciding with a third error -> err_addr keeps the first address until the clear; after the clear err_valid=1, count=1, err_addr = third address.
- m_cyc dropped in BUSY, and rst_n pulsed mid-BUSY -> both return to IDLE with no ack or err; after reset all outputs are at their reset values.
